// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared widths and types for the receive-side I/O buffer
package io_pkg;
   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 4;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/recv_fifo.sv
// rtl/recv_fifo.sv - show-ahead synchronous word FIFO with occupancy count
module recv_fifo
   import io_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            push,
   input  word_t           push_data,
   input  logic            pop,
   output word_t           head,
   output logic            empty,
   output logic            full,
   output logic [ADDR_W:0] count
);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   word_t             mem [DEPTH];
   logic              do_push;
   logic              do_pop;

   // Occupancy drives full/empty so pointer equality is never ambiguous.
   assign empty   = (count == '0);
   assign full    = (count == (ADDR_W+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/io_recv_buffer.sv
// rtl/io_recv_buffer.sv - assembles UART bytes into little-endian words for the core
module io_recv_buffer
   import io_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            rx_valid,
   input  byte_t           rx_data,
   output logic            recv_valid,
   output word_t           recv_data,
   input  logic            recv_pop,
   output logic [ADDR_W:0] word_count,
   output logic            overflow
);

   logic [1:0]  idx;
   logic [23:0] partial;
   logic        word_done;
   word_t       word;
   logic        fifo_empty;
   logic        fifo_full;

   assign word_done  = rx_valid && (idx == 2'(BYTES_PER_WORD-1));
   assign word       = {rx_data, partial};
   assign recv_valid = !fifo_empty;

   // Shifting right leaves the earliest byte in the low lane once three have arrived.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         idx      <= '0;
         partial  <= '0;
         overflow <= 1'b0;
      end else begin
         if (rx_valid) begin
            if (word_done) begin
               idx <= '0;
            end else begin
               idx     <= idx + 1'b1;
               partial <= {rx_data, partial[23:BYTE_W]};
            end
         end
         if (word_done && fifo_full && !(recv_pop && !fifo_empty)) overflow <= 1'b1;
      end
   end

   recv_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (word_done),
      .push_data (word),
      .pop       (recv_pop),
      .head      (recv_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (word_count)
   );

endmodule

// File: tb/tb_io_recv_buffer.sv
// tb/tb_io_recv_buffer.sv - scoreboard bench for io_recv_buffer
module tb_io_recv_buffer;
   import io_pkg::*;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = $clog2(DEPTH);

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            rx_valid = 1'b0;
   byte_t           rx_data = '0;
   logic            recv_valid;
   word_t           recv_data;
   logic            recv_pop = 1'b0;
   logic [ADDR_W:0] word_count;
   logic            overflow;

   int    errors = 0;
   int    checks = 0;
   int    rcv_cnt = 0;
   bit    auto_pop = 1'b0;
   word_t exp_q[$];

   io_recv_buffer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .recv_valid (recv_valid),
      .recv_data  (recv_data),
      .recv_pop   (recv_pop),
      .word_count (word_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted pop is checked against the scoreboard queue.
   always @(negedge clk) begin
      if (rstn && recv_valid && recv_pop) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got %h expected nothing", recv_data);
         end else begin
            word_t e;
            e = exp_q.pop_front();
            rcv_cnt++;
            if (recv_data !== e) begin
               errors++;
               $display("FAIL pop_data: got %h expected %h", recv_data, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_pop) recv_pop = recv_valid;
   endtask

   task automatic do_reset(input int n);
      rstn = 1'b0;
      repeat (n) tick();
      rstn = 1'b1;
      exp_q.delete();
   endtask

   task automatic send_byte(input byte_t b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input word_t w, input bit accept);
      if (accept) exp_q.push_back(w);
      for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
   endtask

   task automatic pop_n(input int n);
      recv_pop = 1'b1;
      repeat (n) tick();
      recv_pop = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset(2);
      chk("rst_valid", 32'(recv_valid), 32'd0);
      chk("rst_count", 32'(word_count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_data", recv_data, 32'h0);

      // Little-endian assembly and push latency
      exp_q.push_back(32'h12345678);
      send_byte(8'h78);
      send_byte(8'h56);
      send_byte(8'h34);
      rx_valid = 1'b1;
      rx_data  = 8'h12;
      #1;
      chk("no_bypass_valid", 32'(recv_valid), 32'd0);
      tick();
      rx_valid = 1'b0;
      chk("t1_valid", 32'(recv_valid), 32'd1);
      chk("t1_data", recv_data, 32'h12345678);
      chk("t1_count", 32'(word_count), 32'd1);
      pop_n(1);
      chk("t1_empty", 32'(recv_valid), 32'd0);

      // Reset mid-word discards the partial bytes
      send_byte(8'h01);
      send_byte(8'h02);
      do_reset(1);
      chk("t2_count_after_rst", 32'(word_count), 32'd0);
      send_word(32'hDDCCBBAA, 1'b1);
      chk("t2_count", 32'(word_count), 32'd1);
      chk("t2_data", recv_data, 32'hDDCCBBAA);
      pop_n(1);

      // Three words, popped with gaps, then a pop while empty
      send_word(32'hA0A1A2A3, 1'b1);
      send_word(32'hB0B1B2B3, 1'b1);
      send_word(32'hC0C1C2C3, 1'b1);
      chk("t3_count", 32'(word_count), 32'd3);
      for (int i = 0; i < 3; i++) begin
         pop_n(1);
         tick();
         tick();
      end
      chk("t3_valid", 32'(recv_valid), 32'd0);
      chk("t3_data_empty", recv_data, 32'h0);
      pop_n(1);
      chk("t3_count_empty_pop", 32'(word_count), 32'd0);

      // Fill, overflow on a dropped word, drain in order
      for (int i = 0; i < DEPTH; i++) send_word(32'h10000000 | 32'(i), 1'b1);
      chk("t4_full_count", 32'(word_count), 32'd16);
      chk("t4_no_ovf", 32'(overflow), 32'd0);
      send_word(32'hDEADBEEF, 1'b0);
      chk("t4_ovf", 32'(overflow), 32'd1);
      chk("t4_count", 32'(word_count), 32'd16);
      chk("t4_head", recv_data, 32'h10000000);
      pop_n(DEPTH);
      chk("t4_drained", 32'(word_count), 32'd0);
      chk("t4_ovf_sticky", 32'(overflow), 32'd1);

      // Full with a same-cycle pop accepts the new word
      do_reset(1);
      chk("t5_ovf_cleared", 32'(overflow), 32'd0);
      for (int i = 0; i < DEPTH; i++) send_word(32'h20000000 | 32'(i), 1'b1);
      exp_q.push_back(32'h5A5A0F0F);
      send_byte(8'h0F);
      send_byte(8'h0F);
      send_byte(8'h5A);
      recv_pop = 1'b1;
      send_byte(8'h5A);
      recv_pop = 1'b0;
      chk("t5_ovf", 32'(overflow), 32'd0);
      chk("t5_count", 32'(word_count), 32'd16);
      chk("t5_head", recv_data, 32'h20000001);
      pop_n(DEPTH);
      chk("t5_drained", 32'(word_count), 32'd0);

      // Streaming 40 words with continuous consumption
      rcv_cnt  = 0;
      auto_pop = 1'b1;
      for (int i = 0; i < 40; i++) send_word(32'h30000000 + 32'(i * 32'h01010101), 1'b1);
      repeat (4) tick();
      auto_pop = 1'b0;
      recv_pop = 1'b0;
      chk("t6_received", 32'(rcv_cnt), 32'd40);
      chk("t6_count", 32'(word_count), 32'd0);
      chk("t6_ovf", 32'(overflow), 32'd0);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
